// File: rtl/switch_debounce_events.sv
// switch_debounce_events: synchronises and debounces one push-button into a level plus press/release/hold pulses.
// Define SWITCH_AUTOREPEAT_EN to re-pulse o_Press every REPEAT_CYCLES after o_Hold while the button stays down.
module switch_debounce_events #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 5000000
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Switch,
    output logic o_Switch,
    output logic o_Press,
    output logic o_Release,
    output logic o_Hold
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int HW = $clog2(HOLD_CYCLES);

    if (DEBOUNCE_CYCLES < 2 || HOLD_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_params
        $error("switch_debounce_events: cycle parameters must be >= 2");
    end

    typedef enum logic [1:0] {S_RELEASED, S_PRESS_WAIT, S_PRESSED, S_RELEASE_WAIT} state_t;

    state_t        state, state_nx;
    logic          meta, sync;
    logic [DW-1:0] db_cnt, db_nx;
    logic [HW-1:0] hold_cnt, hold_nx;
    logic          hold_done, hold_done_nx;
    logic          db_end, hold_top, hold_fire, rpt_fire, in_hi;
    logic          sw_nx, press_nx, rel_nx;

    assign in_hi     = (state == S_PRESSED) || (state == S_RELEASE_WAIT);
    assign db_end    = db_cnt == DW'(DEBOUNCE_CYCLES - 1);
    assign hold_top  = hold_cnt == HW'(HOLD_CYCLES - 1);
    assign hold_fire = (state == S_PRESSED) && hold_top && !hold_done;

    always_ff @(posedge i_Clk or negedge i_Rst_L)
        if (!i_Rst_L) begin
            meta      <= 1'b0;
            sync      <= 1'b0;
            state     <= S_RELEASED;
            db_cnt    <= '0;
            hold_cnt  <= '0;
            hold_done <= 1'b0;
            o_Switch  <= 1'b0;
            o_Press   <= 1'b0;
            o_Release <= 1'b0;
            o_Hold    <= 1'b0;
        end else begin
            meta      <= i_Switch;
            sync      <= meta;
            state     <= state_nx;
            db_cnt    <= db_nx;
            hold_cnt  <= hold_nx;
            hold_done <= hold_done_nx;
            o_Switch  <= sw_nx;
            o_Press   <= press_nx;
            o_Release <= rel_nx;
            o_Hold    <= hold_fire;
        end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_RELEASED:     state_nx = sync ? S_PRESS_WAIT : S_RELEASED;
            S_PRESS_WAIT:   state_nx = !sync ? S_RELEASED : db_end ? S_PRESSED : S_PRESS_WAIT;
            S_PRESSED:      state_nx = sync ? S_PRESSED : S_RELEASE_WAIT;
            S_RELEASE_WAIT: state_nx = sync ? S_PRESSED : db_end ? S_RELEASED : S_RELEASE_WAIT;
            default:        state_nx = S_RELEASED;
        endcase
    end

    // Hold count only advances in S_PRESSED, so release bounces freeze it rather than clear it.
    always_comb begin
        db_nx        = ((state == S_PRESS_WAIT) && sync) || ((state == S_RELEASE_WAIT) && !sync) ? db_cnt + DW'(1) : '0;
        hold_nx      = !in_hi ? '0 : ((state == S_PRESSED) && !hold_top) ? hold_cnt + HW'(1) : hold_cnt;
        hold_done_nx = in_hi && (hold_done || hold_fire);
        sw_nx        = (state_nx == S_PRESSED) || (state_nx == S_RELEASE_WAIT);
        press_nx     = ((state == S_PRESS_WAIT) && (state_nx == S_PRESSED)) || rpt_fire;
        rel_nx       = (state == S_RELEASE_WAIT) && (state_nx == S_RELEASED);
    end

`ifdef SWITCH_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES);

    logic [RW-1:0] rpt_cnt;
    logic          rpt_run;

    assign rpt_run  = (state == S_PRESSED) && hold_done;
    assign rpt_fire = rpt_run && (rpt_cnt == RW'(REPEAT_CYCLES - 1));

    always_ff @(posedge i_Clk or negedge i_Rst_L)
        if (!i_Rst_L)
            rpt_cnt <= '0;
        else
            rpt_cnt <= (!in_hi || hold_fire || rpt_fire) ? '0 : rpt_run ? rpt_cnt + RW'(1) : rpt_cnt;
`else
    assign rpt_fire = 1'b0;
`endif

endmodule

// File: tb/tb_switch_debounce_events.sv
// tb_switch_debounce_events: randomized and directed checks of switch_debounce_events against a run-length reference model.
module tb_switch_debounce_events;
    localparam int DEB = 4, HOLD = 20, REP = 8;
`ifdef SWITCH_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic i_Clk = 1'b0, i_Rst_L = 1'b0, i_Switch = 1'b0;
    logic o_Switch, o_Press, o_Release, o_Hold;
    logic [3:0] dut_o, exp_o;
    int n_cmp = 0, n_bad = 0;

    // Reference: level flips once DEB+1 consecutive synchronised samples disagree with it.
    logic m_q1 = 1'b0, m_q2 = 1'b0, m_level = 1'b0, m_press = 1'b0, m_rel = 1'b0, m_hold = 1'b0, m_fired = 1'b0;
    int   m_run = 0, m_age = 0, m_rep = 0;

    switch_debounce_events #(.DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)) dut (
        .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Switch(i_Switch),
        .o_Switch(o_Switch), .o_Press(o_Press), .o_Release(o_Release), .o_Hold(o_Hold)
    );

    always #5 i_Clk = ~i_Clk;

    assign dut_o = {o_Switch, o_Press, o_Release, o_Hold};
    assign exp_o = {m_level, m_press, m_rel, m_hold};

    initial begin : model
        logic s;
        forever begin
            @(posedge i_Clk or negedge i_Rst_L);
            if (!i_Rst_L) begin
                {m_q1, m_q2, m_level, m_press, m_rel, m_hold, m_fired} = '0;
                m_run = 0; m_age = 0; m_rep = 0;
            end else begin
                s = m_q2; m_q2 = m_q1; m_q1 = i_Switch;
                m_press = 1'b0; m_rel = 1'b0; m_hold = 1'b0;
                if (m_level && m_run == 0) begin
                    m_age++;
                    if (AR && m_fired) begin
                        m_rep++;
                        if (m_rep == REP) begin m_press = 1'b1; m_rep = 0; end
                    end
                    if (!m_fired && m_age == HOLD) begin m_hold = 1'b1; m_fired = 1'b1; m_rep = 0; end
                end
                m_run = (s != m_level) ? m_run + 1 : 0;
                if (m_run == DEB + 1) begin
                    m_level = !m_level; m_run = 0; m_age = 0; m_fired = 1'b0; m_rep = 0;
                    m_press = m_level; m_rel = !m_level;
                end
            end
        end
    end

    task automatic test_reset;
        i_Rst_L = 1'b0; i_Switch = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 5) i_Rst_L = 1'b1;
            @(negedge i_Clk);
            n_cmp++;
            if (dut_o !== 4'b0000) begin n_bad++; $display("FAIL reset cyc %0d: got %b want 0000", i, dut_o); end
        end
    endtask

    task automatic test_clean_press;
        logic [3:0] e;
        for (int i = 0; i < 24; i++) begin
            i_Switch = (i < 10);
            @(negedge i_Clk);
            e = {i >= 6 && i < 16, i == 6, i == 16, 1'b0};
            n_cmp++;
            if (dut_o !== e) begin n_bad++; $display("FAIL clean_press cyc %0d: got %b want %b", i, dut_o, e); end
        end
    endtask

    task automatic test_bounce;
        logic stim[$];
        for (int p = 0; p < 6; p++) begin
            int len = $urandom_range(3, 1);
            repeat (len) stim.push_back(p % 2 == 0);
        end
        repeat (12) stim.push_back(1'b0);
        foreach (stim[i]) begin
            i_Switch = stim[i];
            @(negedge i_Clk);
            n_cmp++;
            if (dut_o !== 4'b0000) begin n_bad++; $display("FAIL bounce cyc %0d: got %b want 0000", i, dut_o); end
        end
    endtask

    task automatic test_long_hold;
        int n_press = 0, n_hold = 0, first_p = -1, last_p = -1, hold_at = -1, rel_at = -1;
        for (int i = 0; i < 56; i++) begin
            i_Switch = (i < 40);
            @(negedge i_Clk);
            n_cmp++;
            if (dut_o !== exp_o) begin n_bad++; $display("FAIL long_hold cyc %0d: got %b want %b", i, dut_o, exp_o); end
            if (o_Press) begin n_press++; if (first_p < 0) first_p = i; last_p = i; end
            if (o_Hold) begin n_hold++; hold_at = i; end
            if (o_Release) rel_at = i;
        end
        n_cmp++;
        if (n_press !== (AR ? 3 : 1) || first_p !== 6 || last_p !== (AR ? 42 : 6)) begin
            n_bad++; $display("FAIL long_hold_press: count %0d first %0d last %0d, want %0d/6/%0d", n_press, first_p, last_p, AR ? 3 : 1, AR ? 42 : 6);
        end
        n_cmp++;
        if (n_hold !== 1 || hold_at !== 26) begin n_bad++; $display("FAIL long_hold_hold: count %0d at %0d, want 1 at 26", n_hold, hold_at); end
        n_cmp++;
        if (rel_at !== 46) begin n_bad++; $display("FAIL long_hold_release: at %0d, want 46", rel_at); end
    endtask

    task automatic test_release_bounce;
        logic stim[$];
        int plen, n_hold = 0, n_rel = 0, low_sw = 0;
        repeat (10) stim.push_back(1'b1);
        for (int p = 0; p < 5; p++) begin
            int lo = $urandom_range(3, 1);
            int hi = $urandom_range(6, 2);
            repeat (lo) stim.push_back(1'b0);
            repeat (hi) stim.push_back(1'b1);
        end
        repeat (25) stim.push_back(1'b1);
        plen = stim.size();
        repeat (14) stim.push_back(1'b0);
        foreach (stim[i]) begin
            i_Switch = stim[i];
            @(negedge i_Clk);
            n_cmp++;
            if (dut_o !== exp_o) begin n_bad++; $display("FAIL release_bounce cyc %0d: got %b want %b", i, dut_o, exp_o); end
            if (o_Hold) n_hold++;
            if (i >= 6 && i < plen + 6) begin
                if (o_Release) n_rel++;
                if (!o_Switch) low_sw++;
            end
        end
        n_cmp++;
        if (n_hold !== 1) begin n_bad++; $display("FAIL release_bounce_hold: count %0d, want 1", n_hold); end
        n_cmp++;
        if (n_rel !== 0 || low_sw !== 0) begin n_bad++; $display("FAIL release_bounce_level: releases %0d low cycles %0d, want 0/0", n_rel, low_sw); end
    endtask

    task automatic test_reset_mid;
        logic [3:0] e;
        i_Switch = 1'b1;
        repeat (3) @(negedge i_Clk);
        i_Rst_L = 1'b0;
        #1;
        n_cmp++;
        if (dut_o !== 4'b0000) begin n_bad++; $display("FAIL reset_mid_debounce: got %b want 0000", dut_o); end
        @(negedge i_Clk);
        i_Rst_L = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge i_Clk);
            e = {i >= 6, i == 6, 2'b00};
            n_cmp++;
            if (dut_o !== e) begin n_bad++; $display("FAIL reset_mid_repress cyc %0d: got %b want %b", i, dut_o, e); end
        end
        #3 i_Rst_L = 1'b0;
        #1;
        n_cmp++;
        if (dut_o !== 4'b0000) begin n_bad++; $display("FAIL reset_mid_hold: got %b want 0000", dut_o); end
        @(negedge i_Clk);
        i_Switch = 1'b0;
        @(negedge i_Clk);
        i_Rst_L = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge i_Clk);
            n_cmp++;
            if (dut_o !== 4'b0000) begin n_bad++; $display("FAIL reset_mid_after cyc %0d: got %b want 0000", i, dut_o); end
        end
    endtask

    task automatic test_random;
        logic v = 1'b0;
        for (int s = 0; s < 50; s++) begin
            int len = ($urandom_range(3, 0) == 0) ? $urandom_range(40, 20) : $urandom_range(8, 1);
            v = !v;
            for (int j = 0; j < len; j++) begin
                i_Switch = v;
                @(negedge i_Clk);
                n_cmp++;
                if (dut_o !== exp_o) begin n_bad++; $display("FAIL random seg %0d cyc %0d: got %b want %b", s, j, dut_o, exp_o); end
            end
        end
        i_Switch = 1'b0;
        for (int j = 0; j < 15; j++) begin
            @(negedge i_Clk);
            n_cmp++;
            if (dut_o !== exp_o) begin n_bad++; $display("FAIL random_settle cyc %0d: got %b want %b", j, dut_o, exp_o); end
        end
    endtask

    initial begin
        test_reset;
        test_clean_press;
        test_bounce;
        test_long_hold;
        test_release_bounce;
        test_reset_mid;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/switch_debounce_events.md
Name: switch_debounce_events

Overview:
Conditions one raw push-button input into a clean debounced level and single-cycle event pulses (press, release, long-hold). It sits between a board switch pin and any clocked consumer that reacts to switch edges, such as LED toggle logic, so consumers need no edge detection of their own. It is built from a two-flop synchroniser, a debounce FSM with a stability counter, and a hold counter.

Parameters:
DEBOUNCE_CYCLES, 250000, cycles the synchronised input must stay stable before a level change is accepted (10 ms at 25 MHz); must be >= 2.
HOLD_CYCLES, 25000000, cycles in the pressed state before o_Hold fires (1 s); must be >= 2.
REPEAT_CYCLES, 5000000, auto-repeat period after hold (used only with the optional feature); must be >= 2.

Ports:
i_Clk  input  1  system clock; the single clock domain.
i_Rst_L  input  1  reset: asynchronous, active-low.
i_Switch  input  1  raw switch pin, asynchronous, bouncy; 1 = pressed.
o_Switch  output  1  debounced level.
o_Press  output  1  one-cycle pulse on each accepted press (and on auto-repeats if enabled).
o_Release  output  1  one-cycle pulse on each accepted release.
o_Hold  output  1  one-cycle pulse, at most once per press, after HOLD_CYCLES pressed.

Behaviour:
- Reset (i_Rst_L = 0, asynchronous): sync flops = 0, state = S_RELEASED, all counters = 0, o_Switch = o_Press = o_Release = o_Hold = 0. Releasing reset with the switch held is treated as a new press, accepted after the normal debounce.
- Synchroniser: two flops. The FSM sees only the second flop (sync).
- Counter widths: $clog2 of the largest parameter each counter must reach.
- FSM states:
  - S_RELEASED:
    - sync = 1 -> S_PRESS_WAIT, debounce counter = 0.
  - S_PRESS_WAIT:
    - sync = 0 -> S_RELEASED; no pulse; o_Switch stays 0.
    - sync = 1 and count == DEBOUNCE_CYCLES-1 -> S_PRESSED, o_Switch <= 1, o_Press pulses, hold counter = 0.
    - otherwise count increments.
  - S_PRESSED:
    - Hold counter increments and saturates at HOLD_CYCLES-1.
    - o_Hold pulses on the cycle the counter first reaches HOLD_CYCLES-1.
    - sync = 0 -> S_RELEASE_WAIT, debounce counter = 0.
  - S_RELEASE_WAIT:
    - o_Switch stays 1.
    - Hold counter is frozen.
    - sync = 1 -> S_PRESSED; no pulse; hold counter resumes, not cleared, and o_Hold does not refire if it already fired.
    - sync = 0 and count == DEBOUNCE_CYCLES-1 -> S_RELEASED, o_Switch <= 0, o_Release pulses.
    - otherwise count increments.
- Latency: raw edge sampled at clock edge k and held stable -> o_Switch changes and the pulse is registered at edge k+DEBOUNCE_CYCLES+2.
- Pulse rules:
  - Every pulse is exactly one cycle wide.
  - o_Press and o_Release are never high in the same cycle.
  - o_Hold never coincides with o_Release.
- Any bounce shorter than DEBOUNCE_CYCLES produces no output change.
- Reset mid-debounce or mid-hold aborts immediately with no pulse.

Optional Feature:
SWITCH_AUTOREPEAT_EN
- Defined:
  - After o_Hold fires, while in S_PRESSED, o_Press re-pulses every REPEAT_CYCLES cycles, using a repeat counter cleared at the o_Hold cycle.
  - The first repeat comes REPEAT_CYCLES cycles after o_Hold.
  - The repeat counter freezes in S_RELEASE_WAIT and clears on entering S_RELEASED.
- Undefined: no repeat counter is built, and o_Press fires exactly once per accepted press.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8.
- Reset with i_Switch=0 for 5 cycles -> all outputs 0 throughout and after reset release.
- Clean press: i_Switch 0->1 sampled at edge k and held -> o_Switch=1 and o_Press=1 at edge k+6 only; o_Press=0 at k+7.
- Bounce: i_Switch toggles 1,0,1,0 with 2-cycle pulses, then stays 0 -> o_Switch stays 0 and no pulse ever asserts.
- Long hold: press held for 40 cycles -> o_Press once, o_Hold once (20 cycles after o_Press), then release gives o_Release at release edge+6. With SWITCH_AUTOREPEAT_EN: o_Press also at o_Hold+8, +16.
- Release bounce: while pressed, i_Switch drops to 0 for 2 cycles then returns to 1 -> no o_Release, o_Switch stays 1, o_Hold fires at most once.
- Reset asserted during S_PRESS_WAIT, 2 cycles after the press is sampled -> outputs 0 immediately (asynchronous). With the switch still held after reset release, o_Press occurs at reset-release edge+6.
